// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bus: ID/EXE/MEM hazard sources and the data-memory handshake in,
// per-register freeze/flush controls and the stall performance counter out.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       id_src1;
    logic [3:0]       id_src2;
    logic             id_use_src1;
    logic             id_use_src2;
    logic [3:0]       exe_dst;
    logic             exe_wb_en;
    logic             exe_mem_r_en;
    logic [3:0]       mem_dst;
    logic             mem_wb_en;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             cnt_clr;
    logic             pc_freeze;
    logic             ifid_freeze;
    logic             ifid_flush;
    logic             idexe_freeze;
    logic             idexe_flush;
    logic             exemem_freeze;
    logic             memwb_flush;
    logic             hazard;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_src1, id_src2, id_use_src1, id_use_src2, exe_dst, exe_wb_en,
               exe_mem_r_en, mem_dst, mem_wb_en, branch_taken, mem_req, mem_ready, cnt_clr,
        input  pc_freeze, ifid_freeze, ifid_flush, idexe_freeze, idexe_flush,
               exemem_freeze, memwb_flush, hazard, stall_cnt
    );

    modport slave (
        input  id_src1, id_src2, id_use_src1, id_use_src2, exe_dst, exe_wb_en,
               exe_mem_r_en, mem_dst, mem_wb_en, branch_taken, mem_req, mem_ready, cnt_clr,
        output pc_freeze, ifid_freeze, ifid_flush, idexe_freeze, idexe_flush,
               exemem_freeze, memwb_flush, hazard, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: RAW / branch / data-memory-wait freeze and flush control.
// Define FORWARDING_EN when a forwarding unit exists, so only load-use hazards stall.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave bus
);
    typedef enum logic {RUN, MWAIT} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic             m1_exe, m2_exe, m1_mem, m2_mem, raw, mem_stall;

    assign m1_exe = bus.id_use_src1 & (bus.id_src1 == bus.exe_dst);
    assign m2_exe = bus.id_use_src2 & (bus.id_src2 == bus.exe_dst);
    assign m1_mem = bus.id_use_src1 & (bus.id_src1 == bus.mem_dst);
    assign m2_mem = bus.id_use_src2 & (bus.id_src2 == bus.mem_dst);

`ifdef FORWARDING_EN
    // Everything but a load in EXE is forwarded; only load-use has to wait a cycle.
    assign raw = bus.exe_mem_r_en & bus.exe_wb_en & (m1_exe | m2_exe);
`else
    assign raw = (bus.exe_wb_en & (m1_exe | m2_exe)) | (bus.mem_wb_en & (m1_mem | m2_mem));
`endif

    assign mem_stall = (state == MWAIT) | (bus.mem_req & ~bus.mem_ready);

    always_comb begin
        state_nxt         = state;
        bus.pc_freeze     = 1'b0;
        bus.ifid_freeze   = 1'b0;
        bus.ifid_flush    = 1'b0;
        bus.idexe_freeze  = 1'b0;
        bus.idexe_flush   = 1'b0;
        bus.exemem_freeze = 1'b0;
        bus.memwb_flush   = 1'b0;
        bus.hazard        = 1'b0;

        case (state)
            RUN:     if (bus.mem_req && !bus.mem_ready) state_nxt = MWAIT;
            MWAIT:   if (bus.mem_ready) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase

        // Memory wait masks branch and RAW: EXE is frozen and re-presents them afterwards.
        if (!rst) begin
            state_nxt = RUN;
        end else if (mem_stall) begin
            bus.pc_freeze     = 1'b1;
            bus.ifid_freeze   = 1'b1;
            bus.idexe_freeze  = 1'b1;
            bus.exemem_freeze = 1'b1;
            bus.memwb_flush   = 1'b1;
        end else if (bus.branch_taken) begin
            bus.ifid_flush  = 1'b1;
            bus.idexe_flush = 1'b1;
        end else if (raw) begin
            bus.pc_freeze   = 1'b1;
            bus.ifid_freeze = 1'b1;
            bus.idexe_flush = 1'b1;
            bus.hazard      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RUN;
            cnt_q <= '0;
        end else begin
            state <= state_nxt;
            if (bus.cnt_clr)
                cnt_q <= '0;
            else if (bus.pc_freeze && cnt_q != '1)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.stall_cnt = cnt_q;
endmodule
